instr_cycle_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the ARMAria core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM/IO wait, and WB.
- It gates the 7-bit instruction ID fed to the combinational control decoder, so datapath controls are only active in execute-class stages.
- It drives IR/PC load strobes, the write-back strobe, I/O handshake waiting, HALT/resume, and a retired-instruction counter.
- It sits between the instruction decoder output and the control decoder input, at core top level.

---
 rtl/arm_seq_pkg.sv | 31 +++
 rtl/rise_detect.sv | 21 ++
 rtl/instr_cycle_sequencer.sv | 148 ++++++++++++++
 tb/tb_instr_cycle_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_seq_pkg.sv
// Shared state encoding, instruction ID constants and the memory-class
// classifier used by the ARMAria instruction sequencer.
package arm_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_IOWAIT = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    localparam int unsigned ID_RESET     = 100;
    localparam int unsigned ID_INSW      = 71;
    localparam int unsigned ID_HALT      = 75;
    localparam int unsigned ID_JUMP      = 72;
    localparam int unsigned ID_BCOND     = 38;
    localparam int unsigned ID_BCOND_IMM = 73;

    localparam int unsigned MEM_ID_LO = 39;
    localparam int unsigned MEM_ID_HI = 55;

    // Loads/stores occupy a contiguous block plus two stragglers.
    function automatic logic is_mem_id(input int unsigned id);
        return ((id >= MEM_ID_LO) && (id <= MEM_ID_HI)) || (id == 67) || (id == 68);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registers a synchronous level and emits a one-cycle pulse on its rising edge.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/instr_cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that gates the instruction ID
// into the control decoder and drives IR/PC/write-back strobes.
module instr_cycle_sequencer
    import arm_seq_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int ID_W     = 7,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ID_W-1:0]  instr_id,
    input  logic             take,
    input  logic             io_confirm,
    input  logic             resume,
    output logic [ID_W-1:0]  core_id,
    output logic             ir_load,
    output logic             pc_load,
    output logic [1:0]       pc_src,
    output logic             mem_active,
    output logic             wb_strobe,
    output logic             io_wait,
    output logic             halted,
    output logic [2:0]       stage,
    output logic [CNT_W-1:0] retired
);

    localparam logic [ID_W-1:0] RESET_ID = ID_W'(ID_RESET);
    localparam logic [ID_W-1:0] INSW_ID  = ID_W'(ID_INSW);
    localparam logic [ID_W-1:0] HALT_ID  = ID_W'(ID_HALT);
    localparam logic [ID_W-1:0] JUMP_ID  = ID_W'(ID_JUMP);
    localparam logic [ID_W-1:0] BC_ID    = ID_W'(ID_BCOND);
    localparam logic [ID_W-1:0] BCI_ID   = ID_W'(ID_BCOND_IMM);
    localparam logic [3:0]      WAIT_LD  = 4'(MEM_WAIT);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             confirm_rise;
    logic             is_mem;
    logic             branch_taken;

    rise_detect u_confirm_edge (
        .clock   (clock),
        .reset   (reset),
        .level_i (io_confirm),
        .rise_o  (confirm_rise)
    );

    assign is_mem       = is_mem_id(32'(instr_id));
    assign branch_taken = (instr_id == JUMP_ID) ||
                          (((instr_id == BC_ID) || (instr_id == BCI_ID)) && take);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
        end
    end

    // Outputs depend only on the current stage plus the live instruction
    // inputs, so datapath controls stay zero outside execute-class stages.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retired_d  = retired_q;
        core_id    = '0;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        pc_src     = 2'd0;
        mem_active = 1'b0;
        wb_strobe  = 1'b0;
        io_wait    = 1'b0;
        halted     = 1'b0;

        unique case (state_q)
            S_RESET: begin
                core_id = RESET_ID;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (instr_id == INSW_ID) begin
                    state_d = S_IOWAIT;
                end else if (instr_id == HALT_ID) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                core_id = instr_id;
                if (is_mem) begin
                    cnt_d   = WAIT_LD;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                core_id    = instr_id;
                mem_active = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_IOWAIT: begin
                core_id = INSW_ID;
                io_wait = 1'b1;
                if (confirm_rise) begin
                    state_d = S_WB;
                end
            end
            S_HALT: begin
                core_id = HALT_ID;
                halted  = 1'b1;
                if (resume) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                core_id   = instr_id;
                wb_strobe = 1'b1;
                pc_load   = 1'b1;
                pc_src    = branch_taken ? 2'd1 : 2'd0;
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign stage   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Scoreboard bench for instr_cycle_sequencer: the driver queues the expected
// write-back of every instruction, the monitor checks it when wb_strobe fires.
module tb_instr_cycle_sequencer;

    localparam int MW  = 2;
    localparam int IDW = 7;
    localparam int CW  = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [IDW-1:0] instr_id = '0;
    logic           take = 1'b0;
    logic           io_confirm = 1'b0;
    logic           resume = 1'b0;
    logic [IDW-1:0] core_id;
    logic           ir_load, pc_load, mem_active, wb_strobe, io_wait, halted;
    logic [1:0]     pc_src;
    logic [2:0]     stage;
    logic [CW-1:0]  retired;

    typedef struct {
        int id;
        int pcsrc;
        int retiredBefore;
        int lat;
        int memCycles;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   expRetired = 0;
    int   curId = 0;

    instr_cycle_sequencer #(.MEM_WAIT(MW), .ID_W(IDW), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .instr_id   (instr_id),
        .take       (take),
        .io_confirm (io_confirm),
        .resume     (resume),
        .core_id    (core_id),
        .ir_load    (ir_load),
        .pc_load    (pc_load),
        .pc_src     (pc_src),
        .mem_active (mem_active),
        .wb_strobe  (wb_strobe),
        .io_wait    (io_wait),
        .halted     (halted),
        .stage      (stage),
        .retired    (retired)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, expected event within budget", name);
    endtask

    task automatic waitStage(input int s);
        int n = 0;
        @(negedge clock);
        while (stage != 3'(s) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (stage != 3'(s)) timeoutFail($sformatf("wait_stage_%0d", s));
    endtask

    task automatic applyStimulus(input int id, input bit tk, input int pcs,
                                 input int lat, input int memc, input bit expectWb);
        waitStage(1);
        checkOutput("retired_at_fetch", int'(retired), expRetired);
        instr_id = IDW'(id);
        take     = tk;
        curId    = id;
        if (expectWb) begin
            sbq.push_back('{id, pcs, expRetired, lat, memc});
            expRetired = (expRetired + 1) % (1 << CW);
        end
    endtask

    // Monitor: tracks per-instruction latency and MEM occupancy, checks on WB.
    initial begin
        int   lat  = 0;
        int   memc = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                lat  = 0;
                memc = 0;
            end else begin
                if (ir_load) begin
                    lat  = 1;
                    memc = 0;
                end else begin
                    lat++;
                end
                if (mem_active) begin
                    memc++;
                    checkOutput("core_id_in_mem", int'(core_id), curId);
                end
                if (wb_strobe) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_wb: got wb_strobe=1 id=%0d, expected no pending instruction",
                                 core_id);
                    end else begin
                        e = sbq.pop_front();
                        checkOutput("wb_core_id", int'(core_id), e.id);
                        checkOutput("wb_pc_src", int'(pc_src), e.pcsrc);
                        checkOutput("wb_pc_load", int'(pc_load), 1);
                        checkOutput("wb_stage", int'(stage), 5);
                        checkOutput("wb_retired", int'(retired), e.retiredBefore);
                        checkOutput("wb_mem_cycles", memc, e.memCycles);
                        if (e.lat != 0) checkOutput("wb_latency", lat, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no end of run, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int n;
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checkOutput("rst_core_id", int'(core_id), 100);
            checkOutput("rst_stage", int'(stage), 0);
            checkOutput("rst_ir_load", int'(ir_load), 0);
            checkOutput("rst_wb_strobe", int'(wb_strobe), 0);
            checkOutput("rst_retired", int'(retired), 0);
        end
        io_confirm = 1'b1;
        reset = 1'b1;

        applyStimulus(4, 0, 0, 4, 0, 1);
        applyStimulus(40, 0, 0, 7, 3, 1);
        applyStimulus(39, 0, 0, 7, 3, 1);
        applyStimulus(55, 1, 0, 7, 3, 1);
        applyStimulus(56, 0, 0, 4, 0, 1);
        applyStimulus(67, 0, 0, 7, 3, 1);
        applyStimulus(68, 0, 0, 7, 3, 1);
        applyStimulus(69, 0, 0, 4, 0, 1);
        applyStimulus(38, 1, 1, 4, 0, 1);
        applyStimulus(38, 0, 0, 4, 0, 1);
        applyStimulus(73, 1, 1, 4, 0, 1);
        applyStimulus(73, 0, 0, 4, 0, 1);
        applyStimulus(72, 0, 1, 4, 0, 1);
        applyStimulus(72, 1, 1, 4, 0, 1);

        applyStimulus(5, 0, 0, 4, 0, 1);
        waitStage(3);
        resume = 1'b1;
        @(negedge clock);
        resume = 1'b0;
        checkOutput("resume_in_exec_halted", int'(halted), 0);

        applyStimulus(71, 0, 0, 0, 0, 1);
        waitStage(6);
        repeat (5) begin
            checkOutput("iowait_flag", int'(io_wait), 1);
            checkOutput("iowait_core_id", int'(core_id), 71);
            @(negedge clock);
        end
        io_confirm = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checkOutput("iowait_low_stage", int'(stage), 6);
        end
        io_confirm = 1'b1;

        applyStimulus(75, 0, 0, 0, 0, 1);
        waitStage(7);
        repeat (10) begin
            checkOutput("halt_flag", int'(halted), 1);
            checkOutput("halt_core_id", int'(core_id), 75);
            @(negedge clock);
        end
        resume = 1'b1;
        @(negedge clock);
        resume = 1'b0;

        n = (1 << CW) - expRetired;
        repeat (n) applyStimulus(8, 0, 0, 4, 0, 1);
        applyStimulus(9, 0, 0, 4, 0, 1);

        applyStimulus(40, 0, 0, 0, 0, 0);
        waitStage(4);
        #2 reset = 1'b0;
        #1;
        checkOutput("midmem_stage", int'(stage), 0);
        checkOutput("midmem_core_id", int'(core_id), 100);
        checkOutput("midmem_mem_active", int'(mem_active), 0);
        checkOutput("midmem_wb_strobe", int'(wb_strobe), 0);
        checkOutput("midmem_pc_load", int'(pc_load), 0);
        checkOutput("midmem_retired", int'(retired), 0);
        expRetired = 0;
        repeat (2) begin
            @(negedge clock);
            checkOutput("midmem_hold_wb", int'(wb_strobe), 0);
        end
        reset = 1'b1;

        applyStimulus(4, 0, 0, 4, 0, 1);
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) timeoutFail("drain_scoreboard");
        reset = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
